// File: rtl/m72_pic_if.sv
// CPU-side bus and interrupt-acknowledge signals for the M72 interrupt controller.
interface m72_pic_if;
    logic       cs;
    logic       stb;
    logic       we;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dout;
    logic       ack;
    logic       inta;
    logic       intr;
    logic [7:0] vec;
    logic       vec_valid;

    modport master (
        output cs, stb, we, a0, din, inta,
        input  dout, ack, intr, vec, vec_valid
    );

    modport slave (
        input  cs, stb, we, a0, din, inta,
        output dout, ack, intr, vec, vec_valid
    );
endinterface

// File: rtl/m72_pic.sv
// m72_pic: single-cascade fixed-priority 8259-style interrupt controller
// for the M72 main CPU. Bit 0 is the highest priority level.
module m72_pic (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] irq_in,
    m72_pic_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_UNINIT,
        ST_ICW2,
        ST_ICW3,
        ST_ICW4,
        ST_READY
    } state_e;

    state_e     state_q;
    logic [7:0] irr_q, isr_q, imr_q, prev_q;
    logic [7:0] irr_d, isr_d;
    logic [4:0] base_q;
    logic       aeoi_q, rsel_q, single_q, need4_q;
    logic       ack_q, intr_q, vec_valid_q;
    logic [7:0] dout_q, vec_q;

    logic       acc, wr, rd, icw1, ocw_ok, ocw2, ns_eoi, sp_eoi;
    logic [7:0] req;
    logic       has_p, has_s, pending, ack_fire;
    logic [2:0] p_idx, s_idx;

    assign bus.dout      = dout_q;
    assign bus.ack       = ack_q;
    assign bus.intr      = intr_q;
    assign bus.vec       = vec_q;
    assign bus.vec_valid = vec_valid_q;

    // Bus access decode: one access per ack, side effects on the ack-raising edge.
    always_comb begin
        acc    = bus.cs & bus.stb & ~ack_q;
        wr     = acc & bus.we;
        rd     = acc & ~bus.we;
        icw1   = wr & ~bus.a0 & bus.din[4];
        ocw_ok = (state_q == ST_READY) || (state_q == ST_UNINIT);
        ocw2   = wr & ~bus.a0 & ocw_ok & (bus.din[4:3] == 2'b00);
        ns_eoi = ocw2 & (bus.din[7:5] == 3'b001);
        sp_eoi = ocw2 & (bus.din[7:5] == 3'b011);
    end

    // Priority resolution: lowest unmasked request must beat the lowest in-service level.
    always_comb begin
        req   = irr_q & ~imr_q;
        has_p = 1'b0;
        p_idx = '0;
        has_s = 1'b0;
        s_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (req[i] && !has_p) begin
                has_p = 1'b1;
                p_idx = 3'(i);
            end
            if (isr_q[i] && !has_s) begin
                has_s = 1'b1;
                s_idx = 3'(i);
            end
        end
        pending  = has_p && (!has_s || (p_idx < s_idx));
        ack_fire = bus.inta & pending;
    end

    // Next IRR/ISR: ordering encodes the collision rules
    // (edge set beats acknowledge clear, ICW1 beats everything, EOI sees pre-ack ISR).
    always_comb begin
        irr_d = irr_q;
        if (ack_fire)
            irr_d[p_idx] = 1'b0;
        irr_d = irr_d | (irq_in & ~prev_q);
        if (icw1)
            irr_d = '0;

        isr_d = isr_q;
        if (ns_eoi && has_s)
            isr_d[s_idx] = 1'b0;
        if (sp_eoi)
            isr_d[bus.din[2:0]] = 1'b0;
        if (ack_fire && !aeoi_q)
            isr_d[p_idx] = 1'b1;
        if (icw1)
            isr_d = '0;
    end

    // Init state machine, register file and registered bus/interrupt outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_UNINIT;
            irr_q       <= '0;
            isr_q       <= '0;
            imr_q       <= '1;
            prev_q      <= '0;
            base_q      <= '0;
            aeoi_q      <= 1'b0;
            rsel_q      <= 1'b0;
            single_q    <= 1'b0;
            need4_q     <= 1'b0;
            ack_q       <= 1'b0;
            intr_q      <= 1'b0;
            vec_valid_q <= 1'b0;
            dout_q      <= '0;
            vec_q       <= '0;
        end else begin
            prev_q      <= irq_in;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            intr_q      <= pending;
            ack_q       <= acc;
            vec_valid_q <= bus.inta;

            if (bus.inta)
                vec_q <= {base_q, (pending ? p_idx : 3'd7)};

            if (rd)
                dout_q <= bus.a0 ? imr_q : (rsel_q ? isr_q : irr_q);

            if (icw1) begin
                imr_q    <= '0;
                aeoi_q   <= 1'b0;
                rsel_q   <= 1'b0;
                single_q <= bus.din[1];
                need4_q  <= bus.din[0];
                state_q  <= ST_ICW2;
            end else if (wr) begin
                case (state_q)
                    ST_ICW2: begin
                        if (bus.a0) begin
                            base_q <= bus.din[7:3];
                            if (!single_q)
                                state_q <= ST_ICW3;
                            else if (need4_q)
                                state_q <= ST_ICW4;
                            else
                                state_q <= ST_READY;
                        end
                    end
                    ST_ICW3: begin
                        if (bus.a0)
                            state_q <= need4_q ? ST_ICW4 : ST_READY;
                    end
                    ST_ICW4: begin
                        if (bus.a0) begin
                            aeoi_q  <= bus.din[1];
                            state_q <= ST_READY;
                        end
                    end
                    default: begin
                        if (bus.a0)
                            imr_q <= bus.din;
                        else if (bus.din[4:3] == 2'b01 && bus.din[1])
                            rsel_q <= bus.din[0];
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m72_pic.sv
// Directed self-checking bench for m72_pic.
module tb_m72_pic;

    logic       clock;
    logic       reset_n;
    logic [7:0] irq_in;
    int         n_checks;
    int         n_fail;
    logic [7:0] rdata;

    m72_pic_if bus ();

    m72_pic u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .irq_in  (irq_in),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_access(input logic we, input logic a0, input logic [7:0] d, output logic [7:0] q);
        bus.cs  = 1'b1;
        bus.stb = 1'b1;
        bus.we  = we;
        bus.a0  = a0;
        bus.din = d;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.ack) break;
        end
        if (!bus.ack)
            check_eq("bus_ack_timeout", {7'b0, bus.ack}, 8'h01);
        q       = bus.dout;
        bus.cs  = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic wr(input logic a0, input logic [7:0] d);
        logic [7:0] unused_q;
        bus_access(1'b1, a0, d, unused_q);
    endtask

    task automatic rd(input logic a0, output logic [7:0] q);
        bus_access(1'b0, a0, 8'h00, q);
    endtask

    // One-cycle pulse; IRR is set at the following edge, intr one edge later.
    task automatic pulse(input logic [7:0] m);
        irq_in = m;
        tick();
        irq_in = '0;
    endtask

    task automatic do_inta(input string tag, input logic [7:0] exp_vec);
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        check_eq({tag, "_valid"}, {7'b0, bus.vec_valid}, 8'h01);
        check_eq({tag, "_vec"}, bus.vec, exp_vec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        irq_in   = '0;
        bus.cs   = 1'b0;
        bus.stb  = 1'b0;
        bus.we   = 1'b0;
        bus.a0   = 1'b0;
        bus.din  = '0;
        bus.inta = 1'b0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_intr", {7'b0, bus.intr}, 8'h00);
        check_eq("rst_ack", {7'b0, bus.ack}, 8'h00);
        check_eq("rst_vec_valid", {7'b0, bus.vec_valid}, 8'h00);
        check_eq("rst_dout", bus.dout, 8'h00);
        check_eq("rst_vec", bus.vec, 8'h00);
        reset_n = 1'b1;
        tick();
        rd(1'b1, rdata);
        check_eq("rst_imr", rdata, 8'hFF);
        pulse(8'h01);
        tick();
        tick();
        check_eq("uninit_masked_intr", {7'b0, bus.intr}, 8'h00);

        // Init: single, ICW4 needed, base 0x20, normal EOI
        wr(1'b0, 8'h13);
        wr(1'b1, 8'h20);
        wr(1'b1, 8'h01);
        wr(1'b1, 8'hF8);
        pulse(8'h01);
        check_eq("irq0_intr_early", {7'b0, bus.intr}, 8'h00);
        tick();
        check_eq("irq0_intr", {7'b0, bus.intr}, 8'h01);
        do_inta("irq0_ack", 8'h20);
        check_eq("irq0_intr_lag", {7'b0, bus.intr}, 8'h01);
        tick();
        check_eq("irq0_intr_drop", {7'b0, bus.intr}, 8'h00);
        check_eq("irq0_valid_once", {7'b0, bus.vec_valid}, 8'h00);
        wr(1'b0, 8'h0B);
        rd(1'b0, rdata);
        check_eq("irq0_isr", rdata, 8'h01);

        // Two simultaneous requests, nesting and non-specific EOI
        wr(1'b0, 8'h20);
        pulse(8'h06);
        tick();
        check_eq("pair_intr", {7'b0, bus.intr}, 8'h01);
        do_inta("pair_ack1", 8'h21);
        tick();
        tick();
        check_eq("pair_blocked", {7'b0, bus.intr}, 8'h00);
        wr(1'b0, 8'h20);
        check_eq("pair_eoi_lag", {7'b0, bus.intr}, 8'h00);
        tick();
        check_eq("pair_eoi_intr", {7'b0, bus.intr}, 8'h01);
        do_inta("pair_ack2", 8'h22);
        rd(1'b0, rdata);
        check_eq("pair_isr", rdata, 8'h04);
        wr(1'b0, 8'h20);
        rd(1'b0, rdata);
        check_eq("pair_isr_clr", rdata, 8'h00);

        // Masked request stays pending in IRR until the mask is lifted
        wr(1'b1, 8'hFA);
        pulse(8'h02);
        tick();
        tick();
        check_eq("mask_intr", {7'b0, bus.intr}, 8'h00);
        wr(1'b0, 8'h0A);
        rd(1'b0, rdata);
        check_eq("mask_irr", rdata, 8'h02);
        wr(1'b1, 8'hF8);
        check_eq("unmask_lag", {7'b0, bus.intr}, 8'h00);
        tick();
        check_eq("unmask_intr", {7'b0, bus.intr}, 8'h01);
        do_inta("unmask_ack", 8'h21);
        wr(1'b0, 8'h60 | 8'h01);
        wr(1'b0, 8'h0B);
        rd(1'b0, rdata);
        check_eq("spec_eoi_isr", rdata, 8'h00);

        // Spurious acknowledge
        do_inta("spur", 8'h27);
        rd(1'b0, rdata);
        check_eq("spur_isr", rdata, 8'h00);

        // Auto-EOI mode
        wr(1'b0, 8'h13);
        wr(1'b1, 8'h20);
        wr(1'b1, 8'h03);
        pulse(8'h08);
        tick();
        check_eq("aeoi_intr", {7'b0, bus.intr}, 8'h01);
        do_inta("aeoi_ack", 8'h23);
        wr(1'b0, 8'h0B);
        rd(1'b0, rdata);
        check_eq("aeoi_isr", rdata, 8'h00);
        tick();
        check_eq("aeoi_intr_drop", {7'b0, bus.intr}, 8'h00);

        // ICW1 clears live IRR/ISR state
        wr(1'b0, 8'h13);
        wr(1'b1, 8'h20);
        wr(1'b1, 8'h01);
        pulse(8'h01);
        tick();
        do_inta("icw1_ack", 8'h20);
        pulse(8'h04);
        tick();
        rd(1'b0, rdata);
        check_eq("pre_icw1_irr", rdata, 8'h04);
        wr(1'b0, 8'h0B);
        rd(1'b0, rdata);
        check_eq("pre_icw1_isr", rdata, 8'h01);
        wr(1'b0, 8'h13);
        rd(1'b1, rdata);
        check_eq("icw1_imr", rdata, 8'h00);
        rd(1'b0, rdata);
        check_eq("icw1_irr", rdata, 8'h00);
        wr(1'b1, 8'h20);
        wr(1'b1, 8'h01);
        wr(1'b0, 8'h0B);
        rd(1'b0, rdata);
        check_eq("icw1_isr", rdata, 8'h00);
        check_eq("icw1_intr", {7'b0, bus.intr}, 8'h00);

        // Reset aborts an in-flight access and acknowledge
        bus.cs   = 1'b1;
        bus.stb  = 1'b1;
        bus.we   = 1'b0;
        bus.a0   = 1'b1;
        bus.inta = 1'b1;
        #2;
        reset_n = 1'b0;
        tick();
        check_eq("rst_abort_ack", {7'b0, bus.ack}, 8'h00);
        check_eq("rst_abort_valid", {7'b0, bus.vec_valid}, 8'h00);
        bus.cs   = 1'b0;
        bus.stb  = 1'b0;
        bus.inta = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_rst_ack", {7'b0, bus.ack}, 8'h00);
            check_eq("post_rst_valid", {7'b0, bus.vec_valid}, 8'h00);
        end
        rd(1'b1, rdata);
        check_eq("post_rst_imr", rdata, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
